switch_rr_arbiter: RTL and testbench
====================================

SWITCH_RR_ARBITER -- requirements
Module: switch_rr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 10: number of requesters; legal range 2..15, because ID 4'hF is reserved for "none".
REQ-002 The module SHALL have parameter QUANTUM, default 8: maximum consecutive grant cycles per ownership; legal range 1..65535.
REQ-003 The module SHALL have port CLOCK_50_I, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RESET_I, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port REQ_I, input, NUM_REQ bits: request lines, already synchronous to CLOCK_50_I (e.g. from SWITCH_I via external synchronizer); bit i is requester i.
REQ-006 The module SHALL have port GRANT_O, output, NUM_REQ bits: registered one-hot grant, or all zero.
REQ-007 The module SHALL have port GRANT_ID_O, output, 4 bits: binary index of the current owner; 4'hF when there is no owner; directly drivable into the hex-to-7-segment converter.
REQ-008 The module SHALL have port BUSY_O, output, 1 bit: high while in the GRANT state.
REQ-009 The module SHALL have port GRANT_START_O, output, 1 bit: one-cycle pulse in the first cycle of each new grant.

Function
REQ-010 The module SHALL implement FSM states IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-011 The module SHALL hold a round-robin pointer ptr (0..NUM_REQ-1): the highest-priority requester for the next arbitration.
REQ-012 Arbitration (IDLE or GAP) SHALL select the first set bit of REQ_I scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
REQ-013 In IDLE or GAP with REQ_I != 0, the next state SHALL be GRANT, the winner becomes owner, and count loads 1.
  - GRANT_O, GRANT_ID_O, BUSY_O and GRANT_START_O assert on the edge that samples the request.
  - Latency from sampled request to grant is 1 cycle.
REQ-014 In IDLE or GAP with REQ_I == 0, the next state SHALL be IDLE and outputs idle: GRANT_O=0, GRANT_ID_O=4'hF, BUSY_O=0.
REQ-015 In GRANT, if REQ_I[owner]==1 and count<QUANTUM, the FSM SHALL stay in GRANT, increment count, keep GRANT_O/GRANT_ID_O unchanged, and hold GRANT_START_O=0.
REQ-016 In GRANT, if REQ_I[owner]==0 or count==QUANTUM (either or both), the FSM SHALL release:
  - next state GAP;
  - ptr <= owner+1, wrapping NUM_REQ-1 -> 0;
  - outputs idle in the GAP cycle.
REQ-017 Consequences of REQ-015/016 (these SHALL hold):
  - an owner holding its request SHALL see GRANT_O high for exactly QUANTUM cycles;
  - a request dropping SHALL clear GRANT_O on the next edge;
  - exactly one dead cycle (GAP) SHALL separate any two grants.
REQ-018 GAP SHALL last exactly one cycle and arbitrate per REQ-012/013/014 using the updated ptr.
REQ-019 A single persistent requester SHALL be re-granted after each GAP; with QUANTUM=1 and all requests held, grants SHALL alternate GRANT/GAP every cycle.
REQ-020 Requests from non-owners SHALL have no effect during GRANT.
REQ-021 ptr SHALL change only on release; count SHALL be QUANTUM-width-sufficient (16 bits) and never exceed QUANTUM.

Reset
REQ-022 RESET_I high SHALL immediately and asynchronously force:
  - state IDLE;
  - ptr=0, count=0;
  - GRANT_O=0, GRANT_ID_O=4'hF, BUSY_O=0, GRANT_START_O=0.
REQ-023 Reset asserted mid-grant SHALL drop GRANT_O without waiting for a clock edge; on the first edge after deassertion, arbitration SHALL start from ptr=0.

Verification (NUM_REQ=10, QUANTUM=4)
REQ-024 Reset, then REQ_I=10'h000 for 10 cycles -> GRANT_O=0, GRANT_ID_O=F, BUSY_O=0 throughout.
REQ-025 REQ_I=10'h004 held -> edge 1: GRANT_O=10'h004, ID=2, GRANT_START_O pulse; 4 grant cycles, 1 GAP cycle, then re-grant to 2; pattern repeats.
REQ-026 REQ_I=10'h3FF held from reset -> owners 0,1,2,...,9,0 in order, each 4 cycles plus 1 GAP.
REQ-027 REQ_I=10'h021 after owner 5 is granted, then bit 5 drops after 2 grant cycles -> GAP on next edge, ptr=6, next grant ID=0 (wrap).
REQ-028 Owner 9 reaches quantum with REQ_I=10'h200 -> ptr wraps to 0, re-grant ID=9; RESET_I pulsed mid-grant -> GRANT_O=0 asynchronously, and the next arbitration starts at ptr 0.

Source files
------------

// File: rtl/switch_rr_arbiter.sv
// switch_rr_arbiter: round-robin arbiter with per-ownership quantum and one-cycle gap between grants
//   CLOCK_50_I    : single clock, rising edge
//   RESET_I       : asynchronous active-high reset
//   REQ_I         : request lines, bit i is requester i (already synchronous)
//   GRANT_O       : registered one-hot grant, or all zero
//   GRANT_ID_O    : binary index of the current owner, 4'hF when nobody owns
//   BUSY_O        : high while a grant is held
//   GRANT_START_O : one-cycle pulse in the first cycle of each new grant
module switch_rr_arbiter #(
    parameter int NUM_REQ = 10,
    parameter int QUANTUM = 8
) (
    input  logic               CLOCK_50_I,
    input  logic               RESET_I,
    input  logic [NUM_REQ-1:0] REQ_I,
    output logic [NUM_REQ-1:0] GRANT_O,
    output logic [3:0]         GRANT_ID_O,
    output logic               BUSY_O,
    output logic               GRANT_START_O
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t             state_q;
    logic [3:0]         ptr_q;
    logic [15:0]        count_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [3:0]         id_q;
    logic               busy_q;
    logic               start_q;
    logic [15:0]        req_pad;
    logic [4:0]         scan_idx;
    logic               win_vld_d;
    logic [3:0]         win_d;
    logic [3:0]         ptr_d;
    logic               hold_d;
    // Zero-padded view lets a 4-bit index address any requester without width games.
    assign req_pad = 16'(REQ_I);
    // Rotating scan: the first requester at or after ptr wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = 4'd0;
        scan_idx  = 5'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + 5'(k);
            scan_idx = (scan_idx >= 5'(NUM_REQ)) ? scan_idx - 5'(NUM_REQ) : scan_idx;
            if (!win_vld_d && req_pad[scan_idx[3:0]]) begin
                win_vld_d = 1'b1;
                win_d     = scan_idx[3:0];
            end
        end
    end
    // While granting, id_q holds the owner; the next pointer is the requester after it.
    assign ptr_d  = (id_q == 4'(NUM_REQ - 1)) ? 4'd0 : id_q + 4'd1;
    assign hold_d = req_pad[id_q] && (count_q < 16'(QUANTUM));
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            count_q <= 16'd0;
            grant_q <= '0;
            id_q    <= 4'hF;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                GRANT: begin
                    if (hold_d) begin
                        count_q <= count_q + 16'd1;
                    end else begin
                        state_q <= GAP;
                        ptr_q   <= ptr_d;
                        grant_q <= '0;
                        id_q    <= 4'hF;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (win_vld_d) begin
                        state_q <= GRANT;
                        count_q <= 16'd1;
                        grant_q <= NUM_REQ'(1) << win_d;
                        id_q    <= win_d;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        id_q    <= 4'hF;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end
    assign GRANT_O       = grant_q;
    assign GRANT_ID_O    = id_q;
    assign BUSY_O        = busy_q;
    assign GRANT_START_O = start_q;
endmodule

// File: tb/tb_switch_rr_arbiter.sv
// tb_switch_rr_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_switch_rr_arbiter;
    localparam int N = 10;
    localparam int Q = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [3:0]   gid;
    logic         busy;
    logic         gstart;
    int           n_checks = 0;
    int           n_err = 0;
    int           m_owner;
    int           m_cnt;
    int           m_ptr;
    bit           m_start;
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] g;
        logic [3:0]   id;
        logic         busy;
        logic         start;
    } vec_t;
    vec_t tbl[16];
    int   starts[$];

    switch_rr_arbiter #(.NUM_REQ(N), .QUANTUM(Q)) dut (
        .CLOCK_50_I(clk),
        .RESET_I(rst),
        .REQ_I(req),
        .GRANT_O(grant),
        .GRANT_ID_O(gid),
        .BUSY_O(busy),
        .GRANT_START_O(gstart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_start = 0;
    endtask

    // One clock edge of the arbiter's behaviour: owner keeps going until it drops or uses up Q cycles,
    // a release leaves one idle cycle, and a free arbiter hands out to the first requester from ptr.
    task automatic model_step(input logic [N-1:0] r);
        int w;
        m_start = 0;
        w = -1;
        if (m_owner >= 0) begin
            if (r[m_owner] && m_cnt < Q) m_cnt++;
            else begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--)
                if (r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                m_start = 1;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".id"}, 32'(gid), (m_owner >= 0) ? 32'(m_owner) : 32'hF);
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".start"}, 32'(gstart), 32'(m_start));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".id"}, 32'(gid), 32'hF);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".start"}, 32'(gstart), 32'd0);
    endtask

    task automatic step(input logic [N-1:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    // Reset is raised between edges and must take effect before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle({tag, ".async"});
        @(posedge clk);
        #1;
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{10'h004, 10'h004, 4'd2,  1'b1, 1'b1};
        tbl[1]  = '{10'h004, 10'h004, 4'd2,  1'b1, 1'b0};
        tbl[2]  = '{10'h00C, 10'h004, 4'd2,  1'b1, 1'b0};
        tbl[3]  = '{10'h3FF, 10'h004, 4'd2,  1'b1, 1'b0};
        tbl[4]  = '{10'h3FF, 10'h000, 4'hF,  1'b0, 1'b0};
        tbl[5]  = '{10'h004, 10'h004, 4'd2,  1'b1, 1'b1};
        tbl[6]  = '{10'h004, 10'h004, 4'd2,  1'b1, 1'b0};
        tbl[7]  = '{10'h000, 10'h000, 4'hF,  1'b0, 1'b0};
        tbl[8]  = '{10'h3FF, 10'h008, 4'd3,  1'b1, 1'b1};
        tbl[9]  = '{10'h3FF, 10'h008, 4'd3,  1'b1, 1'b0};
        tbl[10] = '{10'h3FF, 10'h008, 4'd3,  1'b1, 1'b0};
        tbl[11] = '{10'h3FF, 10'h008, 4'd3,  1'b1, 1'b0};
        tbl[12] = '{10'h3FF, 10'h000, 4'hF,  1'b0, 1'b0};
        tbl[13] = '{10'h3FF, 10'h010, 4'd4,  1'b1, 1'b1};
        tbl[14] = '{10'h000, 10'h000, 4'hF,  1'b0, 1'b0};
        tbl[15] = '{10'h000, 10'h000, 4'hF,  1'b0, 1'b0};

        model_reset();
        @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step('0);
            chk_idle("no_req");
        end

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req);
            chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d.id", i), 32'(gid), 32'(tbl[i].id));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.start", i), 32'(gstart), 32'(tbl[i].start));
        end

        do_reset("all_rst");
        for (int i = 0; i < 51; i++) begin
            step(10'h3FF);
            chk_model("all");
            if (gstart) starts.push_back(int'(gid));
        end
        chk("all.nstarts", 32'(starts.size()), 32'd11);
        foreach (starts[i]) chk($sformatf("all.order%0d", i), 32'(starts[i]), 32'(i % N));

        do_reset("drop_rst");
        step(10'h020);
        chk("drop.id5", 32'(gid), 32'd5);
        step(10'h021);
        chk("drop.hold", 32'(grant), 32'h020);
        step(10'h001);
        chk_idle("drop.gap");
        step(10'h001);
        chk("drop.wrap_id", 32'(gid), 32'd0);
        chk("drop.wrap_start", 32'(gstart), 32'd1);
        step(10'h000);
        step(10'h000);

        do_reset("q9_rst");
        for (int i = 0; i < 7; i++) begin
            step(10'h200);
            chk_model("q9");
        end
        chk("q9.regrant", 32'(gid), 32'd9);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("q9.async_grant", 32'(grant), 32'd0);
        chk("q9.async_id", 32'(gid), 32'hF);
        chk("q9.async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        req = 10'h3FF;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_step(10'h3FF);
        #1;
        chk("q9.ptr0_id", 32'(gid), 32'd0);
        chk_model("q9.after");

        do_reset("rnd_rst");
        begin
            logic [N-1:0] r = '0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0)
                    r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom) & N'($urandom);
                step(r);
                chk_model("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
